// File: rtl/isa_pkg.sv
// +------------------------------------------------------------------+
// | isa_pkg : br32 encoding constants, command opcodes, FSM states    |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none
package isa_pkg;
  typedef enum logic [2:0] {
    OP_LI    = 3'd0,
    OP_ALUI  = 3'd1,
    OP_ALUR  = 3'd2,
    OP_LOAD  = 3'd3,
    OP_STORE = 3'd4,
    OP_JUMP  = 3'd5,
    OP_BCOND = 3'd6,
    OP_RSVD  = 3'd7
  } cmd_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } inj_state_e;

  localparam logic [1:0] MAJ_BRANCH = 2'b00;
  localparam logic [1:0] MAJ_ALUI   = 2'b01;
  localparam logic [1:0] MAJ_MEM    = 2'b10;
  localparam logic [1:0] MAJ_EXT    = 2'b11;

  localparam logic [5:0] LOW_REGREG = 6'h3E;
  localparam logic [3:0] LOW_JUMP   = 4'b0111;
  localparam logic [2:0] ALU_OR     = 3'd3;

  localparam int RD_LSB    = 6;
  localparam int RS1_LSB   = 11;
  localparam int RS2_LSB   = 16;
  localparam int IMM16_LSB = 16;

  function automatic logic [31:0] enc_alui(input logic [15:0] imm16, input logic [4:0] rs1,
                                           input logic [4:0] rd, input logic hi,
                                           input logic [2:0] op);
    return {imm16, rs1, rd, MAJ_ALUI, hi, op};
  endfunction
endpackage
`default_nettype wire

// File: rtl/instr_injector_if.sv
// +------------------------------------------------------------------+
// | instr_injector_if : command port and instruction stream bundle    |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none
interface instr_injector_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [4:0]  cmd_rd;
  logic [4:0]  cmd_rs1;
  logic [4:0]  cmd_rs2;
  logic [5:0]  cmd_fn;
  logic [31:0] cmd_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_last;
  logic        err;

  modport slave (
    input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_fn, cmd_imm, out_ready,
    output cmd_ready, out_valid, out_instr, out_last, err
  );

  modport master (
    output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_fn, cmd_imm, out_ready,
    input  cmd_ready, out_valid, out_instr, out_last, err
  );
endinterface
`default_nettype wire

// File: rtl/instr_encoder.sv
// +------------------------------------------------------------------+
// | instr_encoder : combinational command -> br32 word(s) encoder     |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none
module instr_encoder
  import isa_pkg::*;
(
  input  var cmd_op_e     i_op,
  input  wire logic [4:0]  i_rd,
  input  wire logic [4:0]  i_rs1,
  input  wire logic [4:0]  i_rs2,
  input  wire logic [5:0]  i_fn,
  input  wire logic [31:0] i_imm,
  output logic [31:0]      o_word0,
  output logic [31:0]      o_word1,
  output logic             o_two_words,
  output logic             o_bad
);
  logic w_hi_zero;
  logic w_lo_zero;
  logic w_mem_ok;
  logic w_br_ok;

  assign w_hi_zero = (i_imm[31:16] == 16'h0);
  assign w_lo_zero = (i_imm[15:0] == 16'h0);
  // Memory offsets must sign-extend from 16 bits; branch targets from 28 bits, word aligned.
  assign w_mem_ok  = (&i_imm[31:15]) || (~|i_imm[31:15]);
  assign w_br_ok   = ((&i_imm[31:27]) || (~|i_imm[31:27])) && (i_imm[1:0] == 2'b00);

  always_comb begin
    o_word0     = 32'h0;
    o_word1     = 32'h0;
    o_two_words = 1'b0;
    o_bad       = 1'b0;
    case (i_op)
      OP_LI: begin
        if (w_hi_zero) begin
          o_word0 = enc_alui(i_imm[15:0], 5'd0, i_rd, 1'b0, ALU_OR);
        end else if (w_lo_zero) begin
          o_word0 = enc_alui(i_imm[31:16], 5'd0, i_rd, 1'b1, ALU_OR);
        end else begin
          o_word0     = enc_alui(i_imm[31:16], 5'd0, i_rd, 1'b1, ALU_OR);
          o_word1     = enc_alui(i_imm[15:0], i_rd, i_rd, 1'b0, ALU_OR);
          o_two_words = 1'b1;
        end
      end
      OP_ALUI: begin
        if (w_hi_zero) begin
          o_word0 = enc_alui(i_imm[15:0], i_rs1, i_rd, 1'b0, i_fn[2:0]);
        end else if (w_lo_zero) begin
          o_word0 = enc_alui(i_imm[31:16], i_rs1, i_rd, 1'b1, i_fn[2:0]);
        end else begin
          o_bad = 1'b1;
        end
      end
      OP_ALUR:  o_word0 = {5'b0, i_fn, i_rs2, i_rs1, i_rd, LOW_REGREG};
      OP_LOAD: begin
        o_word0 = {i_imm[15:0], i_rs1, i_rd, MAJ_MEM, i_fn[2:1], 1'b0, i_fn[0]};
        o_bad   = !w_mem_ok;
      end
      OP_STORE: begin
        o_word0 = {i_imm[15:0], i_rs1, i_rd, MAJ_MEM, i_fn[2:1], 2'b10};
        o_bad   = !w_mem_ok;
      end
      OP_JUMP: begin
        o_word0 = {i_imm[27:2], 1'b0, LOW_JUMP, i_fn[0]};
        o_bad   = !w_br_ok;
      end
      OP_BCOND: begin
        o_word0 = {i_imm[27:2], MAJ_BRANCH, 1'b1, i_fn[2:0]};
        o_bad   = !w_br_ok || (i_fn[2:1] == 2'b11);
      end
      default:  o_bad = 1'b1;
    endcase
  end
endmodule
`default_nettype wire

// File: rtl/instr_injector.sv
// +------------------------------------------------------------------+
// | instr_injector : command-driven br32 instruction word generator   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none
module instr_injector
  import isa_pkg::*;
(
  input  wire logic        clk,
  input  wire logic        rst_n,
  instr_injector_if.slave  bus
);
  logic [31:0] w_word0;
  logic [31:0] w_word1;
  logic        w_two_words;
  logic        w_bad;
  logic        w_cmd_ready;
  logic        w_accept;

  inj_state_e  r_state,     w_state_nxt;
  logic        r_out_valid, w_out_valid_nxt;
  logic [31:0] r_out_instr, w_out_instr_nxt;
  logic        r_out_last,  w_out_last_nxt;
  logic        r_err,       w_err_nxt;
  logic [31:0] r_word1,     w_word1_nxt;

  instr_encoder u_encoder (
    .i_op        (cmd_op_e'(bus.cmd_op)),
    .i_rd        (bus.cmd_rd),
    .i_rs1       (bus.cmd_rs1),
    .i_rs2       (bus.cmd_rs2),
    .i_fn        (bus.cmd_fn),
    .i_imm       (bus.cmd_imm),
    .o_word0     (w_word0),
    .o_word1     (w_word1),
    .o_two_words (w_two_words),
    .o_bad       (w_bad)
  );

  assign w_cmd_ready = (r_state == ST_IDLE) && (!r_out_valid || bus.out_ready);
  assign w_accept    = bus.cmd_valid && w_cmd_ready;

  always_comb begin
    w_state_nxt     = r_state;
    w_out_valid_nxt = r_out_valid;
    w_out_instr_nxt = r_out_instr;
    w_out_last_nxt  = r_out_last;
    w_err_nxt       = 1'b0;
    w_word1_nxt     = r_word1;
    case (r_state)
      ST_IDLE: begin
        if (r_out_valid && bus.out_ready) begin
          w_out_valid_nxt = 1'b0;
        end
        if (w_accept) begin
          if (w_bad) begin
            w_err_nxt = 1'b1;
          end else begin
            w_out_valid_nxt = 1'b1;
            w_out_instr_nxt = w_word0;
            w_out_last_nxt  = !w_two_words;
            w_word1_nxt     = w_word1;
            w_state_nxt     = w_two_words ? ST_PEND : ST_IDLE;
          end
        end
      end
      ST_PEND: begin
        // The first word is always valid here; its handshake swaps in the held second word.
        if (bus.out_ready) begin
          w_out_instr_nxt = r_word1;
          w_out_last_nxt  = 1'b1;
          w_state_nxt     = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_out_valid <= 1'b0;
      r_out_instr <= 32'h0;
      r_out_last  <= 1'b0;
      r_err       <= 1'b0;
      r_word1     <= 32'h0;
    end else begin
      r_state     <= w_state_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_instr <= w_out_instr_nxt;
      r_out_last  <= w_out_last_nxt;
      r_err       <= w_err_nxt;
      r_word1     <= w_word1_nxt;
    end
  end

  assign bus.cmd_ready = w_cmd_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_instr = r_out_instr;
  assign bus.out_last  = r_out_last;
  assign bus.err       = r_err;
endmodule
`default_nettype wire

// File: tb/tb_instr_injector.sv
// +------------------------------------------------------------------+
// | tb_instr_injector : directed vector bench for instr_injector      |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none
module tb_instr_injector;
  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  instr_injector_if bus_if ();

  instr_injector dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [5:0]  fn;
    logic [31:0] imm;
    logic        bad;
    logic        two;
    logic [31:0] w0;
    logic [31:0] w1;
  } vec_t;

  vec_t vecs [0:17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus_if.cmd_op  = v.op;
    bus_if.cmd_rd  = v.rd;
    bus_if.cmd_rs1 = v.rs1;
    bus_if.cmd_rs2 = v.rs2;
    bus_if.cmd_fn  = v.fn;
    bus_if.cmd_imm = v.imm;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    n_chk  = 0;
    n_fail = 0;
    //          op    rd     rs1    rs2    fn     imm           bad  two  w0            w1
    vecs[0]  = '{3'd0, 5'd5, 5'd9, 5'd0, 6'd0,  32'h12345678, 1'b0, 1'b1, 32'h1234015B, 32'h56782953};
    vecs[1]  = '{3'd0, 5'd1, 5'd0, 5'd0, 6'd0,  32'h000000FF, 1'b0, 1'b0, 32'h00FF0053, 32'h0};
    vecs[2]  = '{3'd0, 5'd2, 5'd7, 5'd0, 6'd0,  32'hABCD0000, 1'b0, 1'b0, 32'hABCD009B, 32'h0};
    vecs[3]  = '{3'd2, 5'd3, 5'd4, 5'd5, 6'h21, 32'h0,        1'b0, 1'b0, 32'h042520FE, 32'h0};
    vecs[4]  = '{3'd1, 5'd1, 5'd2, 5'd0, 6'd2,  32'h00000010, 1'b0, 1'b0, 32'h00101052, 32'h0};
    vecs[5]  = '{3'd1, 5'd1, 5'd2, 5'd0, 6'd2,  32'h00200000, 1'b0, 1'b0, 32'h0020105A, 32'h0};
    vecs[6]  = '{3'd1, 5'd1, 5'd2, 5'd0, 6'd2,  32'h00010001, 1'b1, 1'b0, 32'h0,        32'h0};
    vecs[7]  = '{3'd4, 5'd7, 5'd2, 5'd0, 6'd4,  32'hFFFFFFFC, 1'b0, 1'b0, 32'hFFFC11EA, 32'h0};
    vecs[8]  = '{3'd3, 5'd3, 5'd1, 5'd0, 6'd3,  32'h00007FFF, 1'b0, 1'b0, 32'h7FFF08E5, 32'h0};
    vecs[9]  = '{3'd3, 5'd3, 5'd1, 5'd0, 6'd3,  32'h00010000, 1'b1, 1'b0, 32'h0,        32'h0};
    vecs[10] = '{3'd3, 5'd3, 5'd1, 5'd0, 6'd3,  32'h00008000, 1'b1, 1'b0, 32'h0,        32'h0};
    vecs[11] = '{3'd5, 5'd0, 5'd0, 5'd0, 6'd1,  32'hFFFFFFF8, 1'b0, 1'b0, 32'hFFFFFF8F, 32'h0};
    vecs[12] = '{3'd5, 5'd0, 5'd0, 5'd0, 6'd1,  32'h00000002, 1'b1, 1'b0, 32'h0,        32'h0};
    vecs[13] = '{3'd6, 5'd0, 5'd0, 5'd0, 6'd6,  32'h00000100, 1'b1, 1'b0, 32'h0,        32'h0};
    vecs[14] = '{3'd6, 5'd0, 5'd0, 5'd0, 6'd5,  32'h00000100, 1'b0, 1'b0, 32'h0000100D, 32'h0};
    vecs[15] = '{3'd5, 5'd0, 5'd0, 5'd0, 6'd0,  32'h08000000, 1'b1, 1'b0, 32'h0,        32'h0};
    vecs[16] = '{3'd7, 5'd1, 5'd1, 5'd1, 6'd0,  32'h0,        1'b1, 1'b0, 32'h0,        32'h0};
    vecs[17] = '{3'd0, 5'd4, 5'd3, 5'd0, 6'd0,  32'h0,        1'b0, 1'b0, 32'h00000113, 32'h0};

    rst_n            = 1'b0;
    bus_if.cmd_valid = 1'b0;
    bus_if.out_ready = 1'b1;
    drive(vecs[1]);
    tick();
    tick();
    chk("reset out_valid", 32'(bus_if.out_valid), 32'h0);
    chk("reset out_instr", bus_if.out_instr, 32'h0);
    chk("reset out_last",  32'(bus_if.out_last), 32'h0);
    chk("reset err",       32'(bus_if.err), 32'h0);
    chk("reset cmd_ready", 32'(bus_if.cmd_ready), 32'h1);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 18; i++) begin
      v = vecs[i];
      drive(v);
      bus_if.cmd_valid = 1'b1;
      chk($sformatf("v%0d cmd_ready", i), 32'(bus_if.cmd_ready), 32'h1);
      tick();
      bus_if.cmd_valid = 1'b0;
      if (v.bad) begin
        chk($sformatf("v%0d err pulse", i), 32'(bus_if.err), 32'h1);
        chk($sformatf("v%0d rejected out_valid", i), 32'(bus_if.out_valid), 32'h0);
        tick();
        chk($sformatf("v%0d err cleared", i), 32'(bus_if.err), 32'h0);
        chk($sformatf("v%0d ready after err", i), 32'(bus_if.cmd_ready), 32'h1);
      end else begin
        chk($sformatf("v%0d out_valid", i), 32'(bus_if.out_valid), 32'h1);
        chk($sformatf("v%0d word0", i), bus_if.out_instr, v.w0);
        chk($sformatf("v%0d last0", i), 32'(bus_if.out_last), 32'(!v.two));
        chk($sformatf("v%0d err", i), 32'(bus_if.err), 32'h0);
        if (v.two) begin
          chk($sformatf("v%0d ready in pend", i), 32'(bus_if.cmd_ready), 32'h0);
          tick();
          chk($sformatf("v%0d out_valid1", i), 32'(bus_if.out_valid), 32'h1);
          chk($sformatf("v%0d word1", i), bus_if.out_instr, v.w1);
          chk($sformatf("v%0d last1", i), 32'(bus_if.out_last), 32'h1);
        end
        tick();
        chk($sformatf("v%0d drained", i), 32'(bus_if.out_valid), 32'h0);
      end
    end

    // Two-word LI held off by the sink while another command waits.
    bus_if.out_ready = 1'b0;
    drive(vecs[0]);
    bus_if.cmd_valid = 1'b1;
    tick();
    drive(vecs[3]);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("stall%0d word0", k), bus_if.out_instr, 32'h1234015B);
      chk($sformatf("stall%0d last", k), 32'(bus_if.out_last), 32'h0);
      chk($sformatf("stall%0d valid", k), 32'(bus_if.out_valid), 32'h1);
      chk($sformatf("stall%0d ready", k), 32'(bus_if.cmd_ready), 32'h0);
      if (k < 2) tick();
    end
    bus_if.out_ready = 1'b1;
    tick();
    chk("stall word1", bus_if.out_instr, 32'h56782953);
    chk("stall last1", 32'(bus_if.out_last), 32'h1);
    chk("stall ready after word1", 32'(bus_if.cmd_ready), 32'h1);
    tick();
    bus_if.cmd_valid = 1'b0;
    chk("b2b alur word", bus_if.out_instr, 32'h042520FE);
    chk("b2b alur valid", 32'(bus_if.out_valid), 32'h1);
    tick();
    chk("b2b drained", 32'(bus_if.out_valid), 32'h0);

    // Reset while the second LI word is pending.
    bus_if.out_ready = 1'b0;
    drive(vecs[0]);
    bus_if.cmd_valid = 1'b1;
    tick();
    bus_if.cmd_valid = 1'b0;
    chk("pend word0", bus_if.out_instr, 32'h1234015B);
    rst_n = 1'b0;
    tick();
    chk("pend rst out_valid", 32'(bus_if.out_valid), 32'h0);
    chk("pend rst out_instr", bus_if.out_instr, 32'h0);
    chk("pend rst cmd_ready", 32'(bus_if.cmd_ready), 32'h1);
    rst_n            = 1'b1;
    bus_if.out_ready = 1'b1;
    tick();
    chk("pend rst no word1 a", 32'(bus_if.out_valid), 32'h0);
    tick();
    chk("pend rst no word1 b", 32'(bus_if.out_valid), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
